slave_assertions: RTL and testbench
===================================

SLAVE_ASSERTIONS -- requirements
Module: slave_assertions

Interface
REQ-001 Parameter NO_OF_SLAVES, default 1: width of the chip-select bus.
REQ-002 Parameter CPOL, default 0: SPI idle clock level.
REQ-003 Parameter CPHA, default 0: SPI clock phase.
REQ-004 Parameter CHAR_LEN, default 8: bits per character.
REQ-005 pclk input 1: system clock; the block has one clock, all logic on its rising edge.
REQ-006 areset input 1: reset, synchronous, active-high.
REQ-007 sclk input 1: SPI serial clock, sampled by pclk.
REQ-008 cs input NO_OF_SLAVES: chip selects, active-low.
REQ-009 mosi0..mosi3 input 1 each: master-out data lines.
REQ-010 miso0..miso3 input 1 each: slave-out data lines.
REQ-011 idle_stable_err output 1: a data line toggled while no slave was selected.
REQ-012 miso_seq_err output 1: a checked miso line changed on a sample edge.
REQ-013 mosi_seq_err output 1: a checked mosi line changed on a sample edge.
REQ-014 frame_err output 1: deselect occurred with a partial character.
REQ-015 bit_cnt output 8: sample edges counted in the current frame.
REQ-016 err_count output 16: cycles that had at least one error.

Function
REQ-017 Every pclk, the block SHALL register sclk_q, cs_q and the checked data lines.
REQ-018 Sclk rise = sclk & ~sclk_q; fall = ~sclk & sclk_q.
REQ-019 Sample edge SHALL be rise when CPOL^CPHA==0, otherwise fall; drive edge is the opposite.
REQ-020 selected SHALL be 1 when any cs bit is 0; several cs bits low at once also count as selected, with no error.
REQ-021 Checked lines: mosi0/miso0 only, unless the quad feature is compiled in (REQ-032).
REQ-022 idle_stable_err SHALL pulse high for exactly one cycle, in the cycle after a checked line differs from its registered value while selected was 0 in both the current and previous cycle; sclk activity is irrelevant to this check.
REQ-023 miso_seq_err SHALL pulse for one cycle, in the cycle after a checked miso line changes in the same pclk cycle as a sample edge while selected is 1.
REQ-024 mosi_seq_err follows the same rule as REQ-023 for the mosi lines.
REQ-025 bit_cnt SHALL increment by 1 on each sample edge while selected, wrap at 255, and clear to 0 the cycle after selected falls.
REQ-026 On a selected 1->0 transition, frame_err SHALL pulse one cycle if bit_cnt mod CHAR_LEN != 0.
REQ-027 A deselect with bit_cnt==0 SHALL produce no frame_err.
REQ-028 Each cycle any error is produced, err_count SHALL increment by exactly 1, saturating at 16'hFFFF; simultaneous errors still add only 1.
REQ-029 A sample edge coinciding with a deselect SHALL be counted before the frame_err evaluation.

Reset
REQ-030 While areset is 1 at a pclk edge, outputs SHALL go to: all error pulses 0, bit_cnt 0, err_count 0; sclk_q SHALL load CPOL, cs_q all ones, data registers 0.
REQ-031 Reset mid-frame SHALL abort the frame silently; no frame_err, and the first post-reset cycle SHALL raise no error.

Configuration
REQ-032 With SLAVE_ASSERTIONS_QUAD_EN defined, lines mosi0..3/miso0..3 SHALL all be checked and any one failing raises the error; without it, only mosi0/miso0 are checked and lines 1-3 are ignored.

Verification
REQ-033 cs=1, sclk held at 0, mosi0 toggling every 40 ns for 8 changes -> 8 idle_stable_err pulses, err_count=8.
REQ-034 cs=0, CPOL=0/CPHA=0, 40 ns sclk half-period, miso0 changed on falling edges, 8 bits, then cs=1 -> no errors, bit_cnt reaches 8, no frame_err.
REQ-035 Same as REQ-034 but miso0 changed on rising edges -> miso_seq_err on each change coinciding with a rise, err_count>0.
REQ-036 cs=0, 5 sample edges, then cs=1 -> frame_err one pulse, bit_cnt returns to 0.
REQ-037 areset=1 after 3 bits of a frame, then cs=1 -> no frame_err, all outputs 0.
REQ-038 Built without SLAVE_ASSERTIONS_QUAD_EN, cs=1, miso2 toggling -> no error; built with the macro -> idle_stable_err pulses.

Source files
------------

// File: rtl/slave_assertions.sv
// slave_assertions: SPI slave-side protocol checker (idle stability, data sequencing, frame length, error count).
// Define SLAVE_ASSERTIONS_QUAD_EN to check mosi0..3/miso0..3 instead of mosi0/miso0 only.
module slave_assertions #(
    parameter int NO_OF_SLAVES = 1,
    parameter int CPOL         = 0,
    parameter int CPHA         = 0,
    parameter int CHAR_LEN     = 8
) (
    input  logic                    pclk,
    input  logic                    areset,
    input  logic                    sclk,
    input  logic [NO_OF_SLAVES-1:0] cs,
    input  logic                    mosi0,
    input  logic                    mosi1,
    input  logic                    mosi2,
    input  logic                    mosi3,
    input  logic                    miso0,
    input  logic                    miso1,
    input  logic                    miso2,
    input  logic                    miso3,
    output logic                    idle_stable_err,
    output logic                    miso_seq_err,
    output logic                    mosi_seq_err,
    output logic                    frame_err,
    output logic [7:0]              bit_cnt,
    output logic [15:0]             err_count
);
`ifdef SLAVE_ASSERTIONS_QUAD_EN
    localparam int N = 4;
    logic [N-1:0] mosi, miso;
    assign mosi = {mosi3, mosi2, mosi1, mosi0};
    assign miso = {miso3, miso2, miso1, miso0};
`else
    localparam int N = 1;
    logic [N-1:0] mosi, miso;
    logic         unused_lines;
    assign mosi = mosi0;
    assign miso = miso0;
    assign unused_lines = ^{mosi1, mosi2, mosi3, miso1, miso2, miso3};
`endif
    logic                    sclk_q, armed;
    logic [NO_OF_SLAVES-1:0] cs_q;
    logic [N-1:0]            mosi_q, miso_q;
    logic                    sel, sel_q, sample, desel;
    logic                    idle_n, miso_n, mosi_n, frame_n;
    logic [7:0]              cnt_inc;
    // armed masks the first cycle after reset, when the history registers hold reset values
    always_comb begin
        sel     = ~&cs;
        sel_q   = ~&cs_q;
        sample  = armed && (((CPOL ^ CPHA) == 0) ? (sclk && !sclk_q) : (!sclk && sclk_q));
        desel   = armed && sel_q && !sel;
        cnt_inc = bit_cnt + 8'(sample);
        idle_n  = armed && !sel && !sel_q && ((mosi != mosi_q) || (miso != miso_q));
        miso_n  = sample && sel && (miso != miso_q);
        mosi_n  = sample && sel && (mosi != mosi_q);
        frame_n = desel && ((cnt_inc % 8'(CHAR_LEN)) != 8'd0);
    end
    always_ff @(posedge pclk) begin
        if (areset) begin
            sclk_q          <= CPOL[0];
            cs_q            <= '1;
            mosi_q          <= '0;
            miso_q          <= '0;
            armed           <= 1'b0;
            idle_stable_err <= 1'b0;
            miso_seq_err    <= 1'b0;
            mosi_seq_err    <= 1'b0;
            frame_err       <= 1'b0;
            bit_cnt         <= '0;
            err_count       <= '0;
        end else begin
            sclk_q          <= sclk;
            cs_q            <= cs;
            mosi_q          <= mosi;
            miso_q          <= miso;
            armed           <= 1'b1;
            idle_stable_err <= idle_n;
            miso_seq_err    <= miso_n;
            mosi_seq_err    <= mosi_n;
            frame_err       <= frame_n;
            bit_cnt         <= desel ? 8'd0 : (sel && sample) ? cnt_inc : bit_cnt;
            if ((idle_n || miso_n || mosi_n || frame_n) && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_slave_assertions.sv
// tb_slave_assertions: directed stimulus with a per-cycle behavioural model plus literal checks.
module tb_slave_assertions;
    localparam int NS = 2, CPOL = 0, CPHA = 0, CL = 8;
`ifdef SLAVE_ASSERTIONS_QUAD_EN
    localparam logic [3:0] MASK = 4'hF;
`else
    localparam logic [3:0] MASK = 4'h1;
`endif
    logic          pclk = 0, areset = 1, sclk = 0;
    logic [NS-1:0] cs = '1;
    logic [3:0]    mosi = 0, miso = 0;
    logic          idle_stable_err, miso_seq_err, mosi_seq_err, frame_err;
    logic [7:0]    bit_cnt;
    logic [15:0]   err_count;
    int total = 0, bad = 0;
    int n_idle = 0, n_frame = 0, n_miso = 0, n_mosi = 0;
    logic          p_sclk;
    logic [NS-1:0] p_cs;
    logic [3:0]    p_mosi, p_miso;
    bit  armed = 0, selc, selp, smp;
    bit  e_idle = 0, e_miso = 0, e_mosi = 0, e_frame = 0;
    int  edges = 0, e_cnt = 0;

    slave_assertions #(.NO_OF_SLAVES(NS), .CPOL(CPOL), .CPHA(CPHA), .CHAR_LEN(CL)) dut (
        .pclk(pclk), .areset(areset), .sclk(sclk), .cs(cs),
        .mosi0(mosi[0]), .mosi1(mosi[1]), .mosi2(mosi[2]), .mosi3(mosi[3]),
        .miso0(miso[0]), .miso1(miso[1]), .miso2(miso[2]), .miso3(miso[3]),
        .idle_stable_err(idle_stable_err), .miso_seq_err(miso_seq_err),
        .mosi_seq_err(mosi_seq_err), .frame_err(frame_err),
        .bit_cnt(bit_cnt), .err_count(err_count));

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, got, exp);
        end
    endtask

    // model: frames are counted as sample edges seen since the chip select went active
    always @(posedge pclk) begin
        if (areset) begin
            {e_idle, e_miso, e_mosi, e_frame} = 0;
            edges = 0; e_cnt = 0; armed = 0;
            p_sclk = CPOL[0]; p_cs = '1; p_mosi = 0; p_miso = 0;
        end else begin
            selc = cs != '1;
            selp = p_cs != '1;
            smp = armed && ((CPOL ^ CPHA) == 0 ? (sclk && !p_sclk) : (!sclk && p_sclk));
            e_idle = armed && !selc && !selp && ((((mosi ^ p_mosi) | (miso ^ p_miso)) & MASK) != 0);
            e_miso = smp && selc && (((miso ^ p_miso) & MASK) != 0);
            e_mosi = smp && selc && (((mosi ^ p_mosi) & MASK) != 0);
            e_frame = 0;
            if (armed && selp && !selc) begin
                e_frame = (((edges + int'(smp)) % 256) % CL) != 0;
                edges = 0;
            end else if (selc && smp) edges = (edges + 1) % 256;
            if ((e_idle || e_miso || e_mosi || e_frame) && e_cnt < 65535) e_cnt++;
            armed = 1;
            p_sclk = sclk; p_cs = cs; p_mosi = mosi; p_miso = miso;
        end
    end

    always @(negedge pclk) begin
        chk("idle_stable_err", idle_stable_err, e_idle);
        chk("miso_seq_err", miso_seq_err, e_miso);
        chk("mosi_seq_err", mosi_seq_err, e_mosi);
        chk("frame_err", frame_err, e_frame);
        chk("bit_cnt", bit_cnt, edges);
        chk("err_count", err_count, e_cnt);
        n_idle += int'(idle_stable_err === 1'b1);
        n_miso += int'(miso_seq_err === 1'b1);
        n_mosi += int'(mosi_seq_err === 1'b1);
        n_frame += int'(frame_err === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge pclk); #2; end
    endtask

    task automatic do_reset();
        areset = 1; sclk = 0; cs = '1; mosi = 0; miso = 0;
        tick(2);
        areset = 0;
        tick(2);
        n_idle = 0; n_frame = 0; n_miso = 0; n_mosi = 0;
    endtask

    task automatic bits(input int n, input bit on_rise, input logic [7:0] pat);
        for (int i = 0; i < n; i++) begin
            sclk = 1;
            if (on_rise) miso[0] = pat[i % 8];
            tick(4);
            sclk = 0;
            if (!on_rise && i < n - 1) miso[0] = pat[(i + 1) % 8];
            tick(4);
        end
    endtask

    initial begin
        do_reset();
        chk("reset bit_cnt", bit_cnt, 0);
        chk("reset err_count", err_count, 0);
        // idle toggling of mosi0
        for (int i = 0; i < 8; i++) begin mosi[0] = ~mosi[0]; tick(4); end
        chk("idle pulses", n_idle, 8);
        chk("idle err_count", err_count, 8);
        // clean 8-bit frame, miso changed on falling edges
        do_reset();
        cs = 2'b10; miso[0] = 1'b1; tick(4);
        bits(8, 0, 8'hA5);
        chk("clean bit_cnt", bit_cnt, 8);
        cs = '1; tick(4);
        chk("clean bit_cnt after", bit_cnt, 0);
        chk("clean err_count", err_count, 0);
        chk("clean frame_err", n_frame, 0);
        // miso changed on sample edges
        do_reset();
        cs = 2'b01; tick(4);
        bits(8, 1, 8'hA5);
        cs = '1; tick(4);
        chk("seq miso pulses", n_miso, 7);
        chk("seq err_count", err_count, 7);
        chk("seq frame_err", n_frame, 0);
        // short frame with both slaves selected
        do_reset();
        cs = 2'b00; miso[0] = 1'b1; tick(4);
        bits(5, 0, 8'hA5);
        cs = '1; tick(4);
        chk("short frame_err", n_frame, 1);
        chk("short bit_cnt", bit_cnt, 0);
        chk("short err_count", err_count, 1);
        // eighth sample edge lands on the deselect cycle
        do_reset();
        cs = 2'b10; miso[0] = 1'b1; tick(4);
        bits(7, 0, 8'hA5);
        chk("coincide bit_cnt", bit_cnt, 7);
        sclk = 1; cs = '1; tick(4);
        sclk = 0; tick(4);
        chk("coincide frame_err", n_frame, 0);
        chk("coincide err_count", err_count, 0);
        // reset mid-frame, data line differs from reset value on first post-reset cycle
        do_reset();
        cs = 2'b10; tick(4);
        bits(3, 0, 8'h00);
        areset = 1; mosi[0] = 1'b1; tick(2);
        areset = 0; cs = '1;
        n_frame = 0; n_idle = 0;
        tick(4);
        chk("abort frame_err", n_frame, 0);
        chk("abort idle", n_idle, 0);
        chk("abort bit_cnt", bit_cnt, 0);
        chk("abort err_count", err_count, 0);
        // lines 1..3 toggling while idle
        do_reset();
        for (int i = 0; i < 4; i++) begin miso[2] = ~miso[2]; tick(4); end
        chk("quad idle pulses", n_idle, MASK[2] ? 4 : 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
